// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus the EX operand-select front end
// that feeds the ALU (a, b, alu_control) in the 5-stage MIPS pipeline.
//
// Optional feature macro: FORWARDING_EN
//   defined   -> EX/MEM and MEM/WB results are forwarded onto the operands.
//   undefined -> no forwarding. The exmem_*/memwb_* result ports are ignored,
//                and load_use_hazard widens to cover any RAW hazard against
//                EX or EX/MEM. The register file must write-before-read so
//                that MEM/WB is covered.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   stall, flush          hold all contents / load a bubble (flush wins)
//   id_*                  decoded operands, specifiers and control from ID
//   exmem_*, memwb_*      forwarding sources (write enable, rd, result)
//   alu_a, alu_b          ALU operands (forwarded, immediate-muxed)
//   alu_control           registered 4-bit ALU op
//   ex_store_data         forwarded rt value for stores
//   ex_write_reg          destination register (rd or rt)
//   ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  registered control
//   ex_valid              EX holds a real instruction
//   load_use_hazard       combinational; IF/ID must hold while high
module id_ex_stage #(
  parameter int unsigned WORD  = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WORD-1:0]  id_rs_data,
  input  logic [WORD-1:0]  id_rt_data,
  input  logic [WORD-1:0]  id_imm,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  input  logic [RADDR-1:0] id_rd,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic [3:0]       id_alu_control,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             exmem_reg_write,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [WORD-1:0]  exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic [WORD-1:0]  memwb_result,
  output logic [WORD-1:0]  alu_a,
  output logic [WORD-1:0]  alu_b,
  output logic [3:0]       alu_control,
  output logic [WORD-1:0]  ex_store_data,
  output logic [RADDR-1:0] ex_write_reg,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_valid,
  output logic             load_use_hazard
);

  typedef struct packed {
    logic             valid;
    logic [WORD-1:0]  rs_data;
    logic [WORD-1:0]  rt_data;
    logic [WORD-1:0]  imm;
    logic [RADDR-1:0] rs;
    logic [RADDR-1:0] rt;
    logic [RADDR-1:0] rd;
    logic             alu_src;
    logic             reg_dst;
    logic [3:0]       alu_control;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
  } idex_t;

  idex_t            q;
  idex_t            d_cap;
  logic [WORD-1:0]  fwd_rs;
  logic [WORD-1:0]  fwd_rt;
  logic [RADDR-1:0] write_reg;
  logic             lu_hit;
  logic             raw_hit;

  // Capture image of the ID inputs; an invalid ID slot never carries control.
  always_comb begin
    d_cap             = '0;
    d_cap.valid       = id_valid;
    d_cap.rs_data     = id_rs_data;
    d_cap.rt_data     = id_rt_data;
    d_cap.imm         = id_imm;
    d_cap.rs          = id_rs;
    d_cap.rt          = id_rt;
    d_cap.rd          = id_rd;
    d_cap.alu_src     = id_alu_src;
    d_cap.reg_dst     = id_reg_dst;
    d_cap.alu_control = id_alu_control;
    if (id_valid) begin
      d_cap.reg_write  = id_reg_write;
      d_cap.mem_read   = id_mem_read;
      d_cap.mem_write  = id_mem_write;
      d_cap.mem_to_reg = id_mem_to_reg;
    end
  end

  // ID/EX register: flush > stall > hazard bubble > capture. A bubble is all zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      if (load_use_hazard) q <= '0;
      else                 q <= d_cap;
    end
  end

  assign write_reg = q.reg_dst ? q.rd : q.rt;

  // Load in EX whose destination (rt) is read by the instruction in ID.
  assign lu_hit = q.valid & q.mem_read & (q.rt != '0) &
                  ((q.rt == id_rs) | (q.rt == id_rt));

`ifdef FORWARDING_EN
  assign raw_hit = 1'b0;

  // EX/MEM has priority over MEM/WB; $0 is never forwarded.
  always_comb begin
    fwd_rs = q.rs_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == q.rs))
      fwd_rs = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == q.rs))
      fwd_rs = memwb_result;
  end

  always_comb begin
    fwd_rt = q.rt_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == q.rt))
      fwd_rt = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == q.rt))
      fwd_rt = memwb_result;
  end
`else
  logic unused_fwd;

  // Without forwarding, any pending write in EX or EX/MEM must stall ID.
  assign raw_hit = (q.valid & q.reg_write & (write_reg != '0) &
                    ((write_reg == id_rs) | (write_reg == id_rt))) |
                   (exmem_reg_write & (exmem_rd != '0) &
                    ((exmem_rd == id_rs) | (exmem_rd == id_rt)));

  assign fwd_rs     = q.rs_data;
  assign fwd_rt     = q.rt_data;
  assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result};
`endif

  assign load_use_hazard = id_valid & (lu_hit | raw_hit);

  assign alu_a         = fwd_rs;
  assign alu_b         = q.alu_src ? q.imm : fwd_rt;
  assign alu_control   = q.alu_control;
  assign ex_store_data = fwd_rt;
  assign ex_write_reg  = write_reg;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
  assign ex_mem_to_reg = q.mem_to_reg;
  assign ex_valid      = q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage. Expected
// values are hand-computed; where forwarding changes the answer the expected
// value is chosen by whether FORWARDING_EN is defined.
module tb_id_ex_stage;

`ifdef FORWARDING_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_alu_src, id_reg_dst;
  logic [3:0]  id_alu_control;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_control;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_valid, load_use_hazard;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage #(.WORD(32), .RADDR(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_alu_control(id_alu_control), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_valid(ex_valid), .load_use_hazard(load_use_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic asrc, input logic rdst,
                        input logic [3:0] ac, input logic rw, input logic mr,
                        input logic mw, input logic m2r);
    id_valid = v; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_alu_src = asrc; id_reg_dst = rdst;
    id_alu_control = ac; id_reg_write = rw; id_mem_read = mr;
    id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = eres;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mres;
  endtask

  initial begin
    // Reset while stalled with a valid ID instruction present.
    reset = 1'b1; stall = 1'b1; flush = 1'b0;
    set_id(1'b1, 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_aluc", 32'(alu_control), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_store", ex_store_data, 32'd0);
    check("rst_wreg", 32'(ex_write_reg), 32'd0);
    check("rst_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'd0);
    check("rst_hazard", 32'(load_use_hazard), 32'd0);
    reset = 1'b0; stall = 1'b0;

    // add $3,$1,$2
    tick();
    check("add_alu_a", alu_a, 32'd5);
    check("add_alu_b", alu_b, 32'd7);
    check("add_aluc", 32'(alu_control), 32'b0010);
    check("add_wreg", 32'(ex_write_reg), 32'd3);
    check("add_regw", 32'(ex_reg_write), 32'd1);
    check("add_valid", 32'(ex_valid), 32'd1);

    // RAW on $3 against EX: stall only without forwarding.
    set_id(1'b1, 32'h0, 32'h0, 32'h0, 5'd3, 5'd9, 5'd9, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("raw_ex_hazard", 32'(load_use_hazard), FE ? 32'd0 : 32'd1);

    // Capture rs=4 / rt=5 consumer.
    set_id(1'b1, 32'h44, 32'h55, 32'h0, 5'd4, 5'd5, 5'd6, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("cons_alu_a", alu_a, 32'h44);
    set_fwd(1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
    #1;
    check("raw_mem_hazard", 32'(load_use_hazard), FE ? 32'd0 : 32'd1);
    id_valid = 1'b0;
    #1;
    check("hazard_gated", 32'(load_use_hazard), 32'd0);
    check("fwd_both_a", alu_a, FE ? 32'h11 : 32'h44);
    set_fwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd4, 32'h22);
    #1;
    check("fwd_memwb_a", alu_a, FE ? 32'h22 : 32'h44);
    set_fwd(1'b1, 5'd5, 32'h11, 1'b1, 5'd4, 32'h22);
    #1;
    check("fwd_split_a", alu_a, FE ? 32'h22 : 32'h44);
    check("fwd_split_b", alu_b, FE ? 32'h11 : 32'h55);
    check("fwd_split_st", ex_store_data, FE ? 32'h11 : 32'h55);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // lw $8, 4($9) followed by sub $10,$8,$2.
    set_id(1'b1, 32'h90, 32'h0, 32'h4, 5'd9, 5'd8, 5'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("lw_mem_read", 32'(ex_mem_read), 32'd1);
    check("lw_alu_b", alu_b, 32'h4);
    set_id(1'b1, 32'h30, 32'h10, 32'h0, 5'd8, 5'd2, 5'd10, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("lu_hazard", 32'(load_use_hazard), 32'd1);
    tick();
    check("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_bubble_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'd0);
    check("lu_bubble_aluc", 32'(alu_control), 32'd0);
    check("lu_cleared", 32'(load_use_hazard), 32'd0);
    tick();
    check("sub_valid", 32'(ex_valid), 32'd1);
    check("sub_aluc", 32'(alu_control), 32'b0110);
    check("sub_alu_a", alu_a, 32'h30);
    check("sub_alu_b", alu_b, 32'h10);
    check("sub_wreg", 32'(ex_write_reg), 32'd10);

    // Load targeting $0 never causes a hazard.
    set_id(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("lu_r0_hazard", 32'(load_use_hazard), 32'd0);

    // flush and stall together: flush wins.
    flush = 1'b1; stall = 1'b1;
    tick();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'd0);
    flush = 1'b0; stall = 1'b0;

    // sw $2, 8($1), then hold for three stalled cycles.
    set_id(1'b1, 32'h100, 32'hABCD, 32'h8, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("sw_mem_write", 32'(ex_mem_write), 32'd1);
    check("sw_alu_a", alu_a, 32'h100);
    check("sw_alu_b", alu_b, 32'h8);
    check("sw_store", ex_store_data, 32'hABCD);
    stall = 1'b1;
    set_id(1'b1, 32'h1234, 32'h5678, 32'h9, 5'd11, 5'd12, 5'd13, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_alu_a", alu_a, 32'h100);
      check("stall_alu_b", alu_b, 32'h8);
      check("stall_mw", 32'(ex_mem_write), 32'd1);
      check("stall_aluc", 32'(alu_control), 32'b0010);
    end
    stall = 1'b0;

    // $0 is never forwarded; immediate selects onto b.
    set_id(1'b1, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_fwd(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hFF);
    id_valid = 1'b0;
    #1;
    check("r0_alu_a", alu_a, 32'h0);
    check("r0_alu_b", alu_b, 32'hFFFFFFFC);
    check("r0_store", ex_store_data, 32'h0);

    // Invalid ID slot captured with control inputs high: no control reaches EX.
    id_reg_write = 1'b1; id_mem_write = 1'b1;
    tick();
    check("inv_valid", 32'(ex_valid), 32'd0);
    check("inv_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'd0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset asserted mid-hazard while stalled clears immediately.
    set_id(1'b1, 32'h0, 32'h0, 32'h0, 5'd9, 5'd8, 5'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(1'b1, 32'h0, 32'h0, 32'h0, 5'd8, 5'd3, 5'd4, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    #1;
    check("pre_rst_hazard", 32'(load_use_hazard), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(ex_valid), 32'd0);
    check("async_rst_mr", 32'(ex_mem_read), 32'd0);
    check("async_rst_hazard", 32'(load_use_hazard), 32'd0);
    tick();
    reset = 1'b0; stall = 1'b0;
    set_id(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("post_rst_valid", 32'(ex_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and EX operand-select front end for the 5-stage MIPS pipeline.
- Sits directly upstream of the ALU. It latches decoded operands and control from ID, then drives the ALU's a, b and 4-bit ALU_control.
- Resolves EX-stage data hazards with EX/MEM and MEM/WB forwarding.
- Flags load-use hazards and inserts one bubble for each.

Parameters:
- WORD, 32, datapath width.
- RADDR, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold all ID/EX contents (downstream stall)
- flush  in  1  load bubble (branch/jump squash)
- id_valid  in  1  ID holds a real instruction
- id_rs_data, id_rt_data  in  WORD  register-file read data
- id_imm  in  WORD  sign/zero-extended immediate
- id_rs, id_rt, id_rd  in  RADDR  source/destination specifiers
- id_alu_src  in  1  1: b = immediate
- id_reg_dst  in  1  1: write reg = rd, 0: rt
- id_alu_control  in  4  ALU op code (0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt)
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
- exmem_reg_write  in  1,  exmem_rd  in  RADDR,  exmem_result  in  WORD  EX/MEM forward source
- memwb_reg_write  in  1,  memwb_rd  in  RADDR,  memwb_result  in  WORD  MEM/WB forward source
- alu_a, alu_b  out  WORD  ALU operands
- alu_control  out  4  registered ALU op
- ex_store_data  out  WORD  forwarded rt value for stores
- ex_write_reg  out  RADDR  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control
- ex_valid  out  1  EX holds a real instruction
- load_use_hazard  out  1  combinational; IF/ID must hold when high

Behaviour:
- Reset, asynchronous: all registered fields clear to 0.
  - This gives ex_valid=0, alu_control=0000 and all control outs 0.
  - alu_a/alu_b/ex_store_data then evaluate to 0, because there is no forward match for rd 0.
- Registered fields: valid, rs_data, rt_data, imm, rs, rt, rd, alu_src, reg_dst, alu_control, reg_write, mem_read, mem_write, mem_to_reg.
- Update priority at each posedge clk: flush > stall > load_use_hazard > normal load.
  - flush: load bubble (valid and all control bits 0, alu_control=0000; data fields don't-care, implemented as 0).
  - stall (no flush): hold every field.
  - load_use_hazard (no flush/stall): load bubble.
  - otherwise: capture all id_* inputs. valid = id_valid. If id_valid=0, control bits are forced to 0.
- load_use_hazard = ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - ex_rt is the registered rt, which is the load destination.
  - Gated by id_valid.
- Forward select for rs (same structure for rt), combinational off registered fields:
  - If exmem_reg_write & exmem_rd != 0 & exmem_rd == rs: use exmem_result.
  - Else if memwb_reg_write & memwb_rd != 0 & memwb_rd == rs: use memwb_result.
  - Else: use registered rs_data.
  - EX/MEM wins when both stages match.
- alu_a = fwd_rs.
- alu_b = alu_src ? imm : fwd_rt.
- ex_store_data = fwd_rt.
- ex_write_reg = reg_dst ? rd : rt.
- Latency: an ID instruction appears on the ALU inputs one cycle after capture. The ALU result is combinational in that same cycle.
- Register $0 is never forwarded.
- Bubbles must never assert reg_write or mem_write.
- Reset asserted mid-stall or mid-hazard clears immediately, with no pending state retained.

Optional Feature:
- FORWARDING_EN defined: forwarding exactly as above.
- FORWARDING_EN undefined: no forwarding.
  - fwd_rs = rs_data, fwd_rt = rt_data.
  - The exmem_*/memwb_* ports remain but are ignored.
  - load_use_hazard widens to any RAW hazard against EX or EX/MEM: an instruction in EX with reg_write and a nonzero ex_write_reg matching id_rs/id_rt, or exmem_reg_write with a nonzero exmem_rd matching.
  - The register file must write-before-read so that MEM/WB is covered.

Test Plan:
- Reset with reset=1 while stall=1 and id_valid=1 -> all outputs 0, ex_valid=0, alu_control=0000; hold is irrelevant.
- add $3,$1,$2 with id_rs_data=5, id_rt_data=7, id_alu_control=0010, reg_dst=1, rd=3 -> next cycle alu_a=5, alu_b=7, alu_control=0010, ex_write_reg=3, ex_reg_write=1.
- EX rs=4, exmem_reg_write=1, exmem_rd=4, exmem_result=0x11, memwb_rd=4, memwb_result=0x22 -> alu_a=0x11. With exmem_rd=0 instead -> alu_a=0x22 (FORWARDING_EN).
- lw $8 in EX (mem_read=1, rt=8) with ID sub using rs=8 -> load_use_hazard=1. Next cycle ex_valid=0 and all control 0, then sub captured after the hazard clears.
- flush=1 and stall=1 together with valid ID data -> bubble loaded (flush wins). stall=1 alone for 3 cycles -> outputs unchanged.
- Forward from rd=0 with exmem_reg_write=1, exmem_result=0xFF, rs=0, rs_data=0 -> alu_a=0. alu_src=1, imm=0xFFFFFFFC -> alu_b=0xFFFFFFFC.
